// File: rtl/sd_seq_pkg.sv
// Shared types and interrupt-status bit positions for the multi-block sequencer.
// The bit positions match the data interrupt layout reported by sd_data_master.
package sd_seq_pkg;

  localparam int INT_DATA_SIZE  = 5;
  localparam int INT_DATA_CC    = 0;
  localparam int INT_DATA_EI    = 1;
  localparam int INT_DATA_CTE   = 2;
  localparam int INT_DATA_CCRCE = 3;
  localparam int INT_DATA_CFE   = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    ACK    = 3'd3,
    GAP    = 3'd4,
    STOP   = 3'd5,
    DONE   = 3'd6
  } seq_state_t;

  // A block counts as completed only when it finished cleanly.
  function automatic logic blk_ok(input logic [INT_DATA_SIZE-1:0] st);
    return st[INT_DATA_CC] & ~st[INT_DATA_EI];
  endfunction

  function automatic logic blk_err(input logic [INT_DATA_SIZE-1:0] st);
    return st[INT_DATA_EI];
  endfunction

endpackage

// File: rtl/sd_block_sequencer_gap_counter.sv
// Loadable down-counter that times the idle gap between consecutive blocks.
// Holds at zero; zero_o is the terminal flag seen by the sequencer.
module sd_seq_gap_counter #(
  parameter int GAP_W = 8
) (
  input  logic             sd_clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [GAP_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [GAP_W-1:0] cnt_r;

  // Load takes priority over decrement; decrement stops at zero.
  always_ff @(posedge sd_clk) begin
    if (!rst) begin
      cnt_r <= {GAP_W{1'b0}};
    end else if (load_i) begin
      cnt_r <= load_val_i;
    end else if (dec_i && (cnt_r != {GAP_W{1'b0}})) begin
      cnt_r <= cnt_r - {{(GAP_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero_o = (cnt_r == {GAP_W{1'b0}});

endmodule

// File: rtl/sd_block_sequencer.sv
// Multi-block transfer sequencer: launches sd_data_master once per block,
// acknowledges each block status, counts good blocks and requests CMD12 when needed.
module sd_block_sequencer
  import sd_seq_pkg::*;
#(
  parameter int BLKCNT_W = 16,
  parameter int GAP_W    = 8
) (
  input  logic                     sd_clk,
  input  logic                     rst,
  input  logic                     go_i,
  input  logic                     dir_tx_i,
  input  logic [BLKCNT_W-1:0]      blk_cnt_i,
  input  logic [GAP_W-1:0]         gap_i,
  input  logic                     abort_i,
  output logic                     start_tx_o,
  output logic                     start_rx_o,
  input  logic [INT_DATA_SIZE-1:0] dm_int_status_i,
  output logic                     dm_int_rst_o,
  output logic                     stop_req_o,
  input  logic                     stop_ack_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [BLKCNT_W-1:0]      blks_done_o,
  output logic [INT_DATA_SIZE-1:0] err_status_o,
  output logic                     aborted_o
);

  localparam logic [BLKCNT_W-1:0] BLK_ONE = {{(BLKCNT_W-1){1'b0}}, 1'b1};

  seq_state_t               state_r;
  logic                     dir_r;
  logic [BLKCNT_W-1:0]      blk_cnt_r;
  logic [GAP_W-1:0]         gap_r;
  logic [INT_DATA_SIZE-1:0] status_r;
  logic [BLKCNT_W-1:0]      blks_done_r;
  logic [INT_DATA_SIZE-1:0] err_r;
  logic                     aborted_r;
  logic                     busy_r;
  logic                     done_r;
  logic                     start_tx_r;
  logic                     start_rx_r;
  logic                     dm_int_rst_r;
  logic                     stop_req_r;
  logic [BLKCNT_W-1:0]      blks_next_s;
  logic                     gap_load_s;
  logic                     gap_dec_s;
  logic                     gap_zero_s;
  logic                     status_idle_s;

  assign status_idle_s = (dm_int_status_i == {INT_DATA_SIZE{1'b0}});
  assign gap_load_s    = (state_r == ACK);
  assign gap_dec_s     = (state_r == GAP);

  // Completed-block count as it will be after the current ACK, saturating.
  always_comb begin
    blks_next_s = blks_done_r;
    if (blk_ok(status_r) && (blks_done_r != {BLKCNT_W{1'b1}})) begin
      blks_next_s = blks_done_r + BLK_ONE;
    end else begin
      blks_next_s = blks_done_r;
    end
  end

  sd_seq_gap_counter #(.GAP_W(GAP_W)) u_gap (
    .sd_clk     (sd_clk),
    .rst        (rst),
    .load_i     (gap_load_s),
    .load_val_i (gap_r - {{(GAP_W-1){1'b0}}, 1'b1}),
    .dec_i      (gap_dec_s),
    .zero_o     (gap_zero_s)
  );

  // Sequencer FSM; every output is a register updated on the transition edge.
  always_ff @(posedge sd_clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      dir_r        <= 1'b0;
      blk_cnt_r    <= {BLKCNT_W{1'b0}};
      gap_r        <= {GAP_W{1'b0}};
      status_r     <= {INT_DATA_SIZE{1'b0}};
      blks_done_r  <= {BLKCNT_W{1'b0}};
      err_r        <= {INT_DATA_SIZE{1'b0}};
      aborted_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      start_tx_r   <= 1'b0;
      start_rx_r   <= 1'b0;
      dm_int_rst_r <= 1'b0;
      stop_req_r   <= 1'b0;
    end else begin
      start_tx_r   <= 1'b0;
      start_rx_r   <= 1'b0;
      dm_int_rst_r <= 1'b0;
      done_r       <= 1'b0;
      case (state_r)
        IDLE: begin
          if (go_i) begin
            if (blk_cnt_i == {BLKCNT_W{1'b0}}) begin
              done_r <= 1'b1;
            end else begin
              dir_r       <= dir_tx_i;
              blk_cnt_r   <= blk_cnt_i;
              gap_r       <= gap_i;
              blks_done_r <= {BLKCNT_W{1'b0}};
              err_r       <= {INT_DATA_SIZE{1'b0}};
              aborted_r   <= 1'b0;
              busy_r      <= 1'b1;
              start_tx_r  <= dir_tx_i;
              start_rx_r  <= ~dir_tx_i;
              state_r     <= LAUNCH;
            end
          end
        end
        LAUNCH: state_r <= WAIT;
        WAIT: begin
          if (abort_i) begin
            // A status landing with the abort is still acknowledged.
            dm_int_rst_r <= ~status_idle_s;
            aborted_r    <= 1'b1;
            stop_req_r   <= 1'b1;
            state_r      <= STOP;
          end else if (!status_idle_s) begin
            status_r     <= dm_int_status_i;
            dm_int_rst_r <= 1'b1;
            state_r      <= ACK;
          end
        end
        ACK: begin
          blks_done_r <= blks_next_s;
          if (blk_err(status_r)) begin
            err_r      <= err_r | status_r;
            stop_req_r <= 1'b1;
            state_r    <= STOP;
          end else if (blks_next_s == blk_cnt_r) begin
            if (blk_cnt_r > BLK_ONE) begin
              stop_req_r <= 1'b1;
              state_r    <= STOP;
            end else begin
              state_r <= DONE;
            end
          end else if (gap_r == {GAP_W{1'b0}}) begin
            start_tx_r <= dir_r;
            start_rx_r <= ~dir_r;
            state_r    <= LAUNCH;
          end else begin
            state_r <= GAP;
          end
        end
        GAP: begin
          if (abort_i) begin
            aborted_r  <= 1'b1;
            stop_req_r <= 1'b1;
            state_r    <= STOP;
          end else if (gap_zero_s && status_idle_s) begin
            start_tx_r <= dir_r;
            start_rx_r <= ~dir_r;
            state_r    <= LAUNCH;
          end
        end
        STOP: begin
          if (stop_ack_i) begin
            stop_req_r <= 1'b0;
            state_r    <= DONE;
          end
        end
        DONE: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign start_tx_o   = start_tx_r;
  assign start_rx_o   = start_rx_r;
  assign dm_int_rst_o = dm_int_rst_r;
  assign stop_req_o   = stop_req_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;
  assign blks_done_o  = blks_done_r;
  assign err_status_o = err_r;
  assign aborted_o    = aborted_r;

endmodule
